rv32_lsu: RTL and testbench

Load/store unit downstream of the RV32 ALU. It takes the effective address the ALU computes for loads and stores (`reg_s1` + sign-extended immediate) and runs one data-memory transaction over a valid/ack bus. Store data is lane-aligned and byte enables are generated; load data is aligned and sign- or zero-extended. Results go to register writeback, and misaligned, illegal or timed-out accesses are reported as faults.

---
 rtl/rv32_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_rv32_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: one valid/ack data-memory transaction per request with lane
// formatting, load extension and fault reporting. Optional macro LSU_TIMEOUT_EN adds a bus timeout.
module rv32_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        fault_valid,
    output logic [1:0]  fault_code
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("rv32_lsu: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [0:0] state_r;
    logic       store_r;
    logic [2:0] funct3_r;
    logic [1:0] addr_lo_r;

    logic        accept_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic        go_bus_s;
    logic        timeout_hit_s;
    logic [35:0] store_fmt_s;

    // Store lane formatting: returns {byte_enables, replicated_write_data}.
    function automatic logic [35:0] format_store(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] sd);
        logic [35:0] res;
        case (f3[1:0])
            2'b00:   res = {4'b0001 << lo, {4{sd[7:0]}}};
            2'b01:   res = {4'b0011 << {lo[1], 1'b0}, {2{sd[15:0]}}};
            default: res = {4'b1111, sd};
        endcase
        return res;
    endfunction

    // Load alignment and extension from the returned word.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] res;
        b = rd >> {lo, 3'b000};
        case (f3)
            3'b000:  res = {{24{b[7]}}, b[7:0]};
            3'b100:  res = {24'h000000, b[7:0]};
            3'b001:  res = {{16{b[15]}}, b[15:0]};
            3'b101:  res = {16'h0000, b[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    assign req_ready = (state_r == ST_IDLE);

    // Request decode: illegal encodings first, then natural-alignment check.
    always_comb begin
        accept_s     = req_valid && req_ready;
        illegal_s    = 1'b0;
        misaligned_s = 1'b0;
        if (req_store) begin
            illegal_s = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
        end else begin
            illegal_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b01:   misaligned_s = addr[0];
            2'b10:   misaligned_s = (addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        go_bus_s    = accept_s && !illegal_s && !misaligned_s;
        store_fmt_s = format_store(funct3, addr[1:0], store_data);
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timer_r;

    // Bus wait counter: cleared on entry to BUS, counts every BUS cycle without ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= 16'h0000;
        end else if (go_bus_s) begin
            timer_r <= 16'h0000;
        end else if ((state_r == ST_BUS) && !mem_ack) begin
            timer_r <= timer_r + 16'h0001;
        end else begin
            timer_r <= timer_r;
        end
    end

    // The last permitted wait cycle without ack ends the access; an ack in that cycle wins.
    always_comb begin
        timeout_hit_s = (state_r == ST_BUS) && !mem_ack && (timer_r == TIMEOUT_LAST);
    end
`else
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Main FSM with registered bus, writeback and fault outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            store_r     <= 1'b0;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0000_0000;
            mem_wdata   <= 32'h0000_0000;
            mem_be      <= 4'b0000;
            wb_valid    <= 1'b0;
            wb_data     <= 32'h0000_0000;
            done        <= 1'b0;
            fault_valid <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            wb_valid    <= 1'b0;
            done        <= 1'b0;
            fault_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && illegal_s) begin
                        fault_valid <= 1'b1;
                        fault_code  <= FC_ILLEGAL;
                        done        <= 1'b1;
                    end else if (accept_s && misaligned_s) begin
                        fault_valid <= 1'b1;
                        fault_code  <= FC_MISALIGN;
                        done        <= 1'b1;
                    end else if (go_bus_s) begin
                        state_r   <= ST_BUS;
                        store_r   <= req_store;
                        funct3_r  <= funct3;
                        addr_lo_r <= addr[1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= req_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= req_store ? store_fmt_s[35:32] : 4'b1111;
                        mem_wdata <= req_store ? store_fmt_s[31:0] : 32'h0000_0000;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        state_r <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!store_r) begin
                            wb_valid <= 1'b1;
                            wb_data  <= format_load(funct3_r, addr_lo_r, mem_rdata);
                        end else begin
                            wb_valid <= 1'b0;
                        end
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_IDLE;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        done        <= 1'b1;
                        fault_valid <= 1'b1;
                        fault_code  <= FC_TIMEOUT;
                    end else begin
                        state_r <= ST_BUS;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed self-checking bench for rv32_lsu: loads, stores, faults, back-to-back,
// reset during a bus wait, and (with LSU_TIMEOUT_EN) the bus timeout.
module tb_rv32_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        done;
    logic        fault_valid;
    logic [1:0]  fault_code;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_wb = 32'h0;

    rv32_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .done(done), .fault_valid(fault_valid), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ack = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        n_cmp++; if ({mem_req, mem_we, mem_be, wb_valid, done, fault_valid} !== 9'b0) begin n_err++; $display("FAIL reset ctrl: got %b want 0", {mem_req, mem_we, mem_be, wb_valid, done, fault_valid}); end
        n_cmp++; if ({mem_addr, mem_wdata, wb_data, fault_code} !== 98'b0) begin n_err++; $display("FAIL reset data: got %h %h %h %b want 0", mem_addr, mem_wdata, wb_data, fault_code); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        step();
        n_cmp++; if ({mem_req, done, wb_valid} !== 3'b000) begin n_err++; $display("FAIL stale ack: got %b want 000", {mem_req, done, wb_valid}); end
        mem_ack = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [6] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b001};
        logic [31:0] ad  [6] = '{32'h1003, 32'h2002, 32'h2000, 32'h0010, 32'h5001, 32'h6002};
        logic [31:0] rd  [6] = '{32'h80112233, 32'hBEEF1234, 32'h00008001, 32'hDEADBEEF, 32'h0000A500, 32'h7FFF0000};
        logic [31:0] ex  [6] = '{32'hFFFFFF80, 32'h0000BEEF, 32'hFFFF8001, 32'hDEADBEEF, 32'h000000A5, 32'h00007FFF};
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_store = 1'b0; funct3 = f3[i]; addr = ad[i];
            step();
            req_valid = 1'b0;
            n_cmp++; if ({mem_req, mem_we, mem_be, req_ready} !== 7'b1011110) begin n_err++; $display("FAIL load%0d bus ctrl: got %b want 1011110", i, {mem_req, mem_we, mem_be, req_ready}); end
            n_cmp++; if (mem_addr !== {ad[i][31:2], 2'b00}) begin n_err++; $display("FAIL load%0d mem_addr: got %h want %h", i, mem_addr, {ad[i][31:2], 2'b00}); end
            for (int w = 0; w < (i % 3); w++) begin
                mem_rdata = 32'h5A5A5A5A;
                step();
                n_cmp++; if ({mem_req, done} !== 2'b10) begin n_err++; $display("FAIL load%0d wait%0d: got %b want 10", i, w, {mem_req, done}); end
            end
            mem_ack = 1'b1; mem_rdata = rd[i];
            step();
            mem_ack = 1'b0;
            n_cmp++; if ({wb_valid, done, req_ready, mem_req, fault_valid} !== 5'b11100) begin n_err++; $display("FAIL load%0d complete: got %b want 11100", i, {wb_valid, done, req_ready, mem_req, fault_valid}); end
            n_cmp++; if (wb_data !== ex[i]) begin n_err++; $display("FAIL load%0d wb_data: got %h want %h", i, wb_data, ex[i]); end
            step();
            n_cmp++; if ({wb_valid, done} !== 2'b00 || wb_data !== ex[i]) begin n_err++; $display("FAIL load%0d pulse/hold: got %b %h want 00 %h", i, {wb_valid, done}, wb_data, ex[i]); end
            last_wb = ex[i];
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ad [3] = '{32'h3002, 32'h3001, 32'h3000};
        logic [31:0] sd [3] = '{32'h0000ABCD, 32'h12345677, 32'hCAFEF00D};
        logic [31:0] ew [3] = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
        logic [3:0]  eb [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_store = 1'b1; funct3 = f3[i]; addr = ad[i]; store_data = sd[i];
            step();
            req_valid = 1'b0; store_data = 32'h0;
            n_cmp++; if ({mem_req, mem_we, mem_be} !== {2'b11, eb[i]}) begin n_err++; $display("FAIL store%0d ctrl: got %b want %b", i, {mem_req, mem_we, mem_be}, {2'b11, eb[i]}); end
            n_cmp++; if (mem_wdata !== ew[i] || mem_addr !== 32'h3000) begin n_err++; $display("FAIL store%0d data: got %h @%h want %h @3000", i, mem_wdata, mem_addr, ew[i]); end
            step();
            n_cmp++; if ({mem_req, mem_we, mem_be} !== {2'b11, eb[i]} || mem_wdata !== ew[i]) begin n_err++; $display("FAIL store%0d hold: got %b %h", i, {mem_req, mem_we, mem_be}, mem_wdata); end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            n_cmp++; if ({done, wb_valid, mem_req, fault_valid} !== 4'b1000 || wb_data !== last_wb) begin n_err++; $display("FAIL store%0d complete: got %b %h want 1000 %h", i, {done, wb_valid, mem_req, fault_valid}, wb_data, last_wb); end
            step();
        end
        req_store = 1'b0;
    endtask

    task automatic test_faults();
        logic        st [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{3'b010, 3'b011, 3'b011, 3'b101, 3'b010};
        logic [31:0] ad [5] = '{32'h4001, 32'h4000, 32'h4001, 32'h4003, 32'h4002};
        logic [1:0]  ec [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_store = st[i]; funct3 = f3[i]; addr = ad[i];
            step();
            req_valid = 1'b0;
            n_cmp++; if ({fault_valid, done, wb_valid, mem_req, req_ready} !== 5'b11001) begin n_err++; $display("FAIL fault%0d ctrl: got %b want 11001", i, {fault_valid, done, wb_valid, mem_req, req_ready}); end
            n_cmp++; if (fault_code !== ec[i]) begin n_err++; $display("FAIL fault%0d code: got %b want %b", i, fault_code, ec[i]); end
            step();
            n_cmp++; if ({fault_valid, done, mem_req} !== 3'b000) begin n_err++; $display("FAIL fault%0d pulse: got %b want 000", i, {fault_valid, done, mem_req}); end
        end
        req_store = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Fault followed immediately by a load in the fault-report cycle.
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'h7002;
        step();
        n_cmp++; if ({fault_valid, req_ready} !== 2'b11) begin n_err++; $display("FAIL b2b fault: got %b want 11", {fault_valid, req_ready}); end
        addr = 32'h7004;
        step();
        req_valid = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h7004) begin n_err++; $display("FAIL b2b accept after fault: got %b @%h", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_ack = 1'b0;
        req_valid = 1'b1; funct3 = 3'b100; addr = 32'h8003;
        n_cmp++; if ({wb_valid, req_ready} !== 2'b11 || wb_data !== 32'h11111111) begin n_err++; $display("FAIL b2b first: got %b %h", {wb_valid, req_ready}, wb_data); end
        step();
        req_valid = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000 || wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b second req: got %b @%h wbv %b", mem_req, mem_addr, wb_valid); end
        mem_ack = 1'b1; mem_rdata = 32'hF2000000;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h000000F2) begin n_err++; $display("FAIL b2b second data: got %b %h want 1 000000f2", wb_valid, wb_data); end
        last_wb = 32'h000000F2;
        step();
    endtask

    task automatic test_reset_in_bus();
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'h9000;
        step();
        req_valid = 1'b0;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_bus wait: got %b want 1", mem_req); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if ({mem_req, done, wb_valid, req_ready} !== 4'b0001) begin n_err++; $display("FAIL rst_bus abort: got %b want 0001", {mem_req, done, wb_valid, req_ready}); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({mem_req, done, wb_valid} !== 3'b000) begin n_err++; $display("FAIL rst_bus late ack: got %b want 000", {mem_req, done, wb_valid}); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'hA000;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if ({mem_req, done} !== 2'b10) begin n_err++; $display("FAIL timeout wait c%0d: got %b want 10", c, {mem_req, done}); end
            step();
        end
        n_cmp++; if ({mem_req, fault_valid, done, wb_valid, fault_code} !== 6'b011011) begin n_err++; $display("FAIL timeout fault: got %b want 011011", {mem_req, fault_valid, done, wb_valid, fault_code}); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({mem_req, fault_valid, done, wb_valid} !== 4'b0000) begin n_err++; $display("FAIL timeout late ack: got %b want 0000", {mem_req, fault_valid, done, wb_valid}); end
        // Ack in the final permitted cycle wins over the timeout.
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'hA004;
        step();
        req_valid = 1'b0;
        step(); step(); step();
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({wb_valid, done, fault_valid} !== 3'b110 || wb_data !== 32'h0BADF00D) begin n_err++; $display("FAIL timeout ack wins: got %b %h want 110 0badf00d", {wb_valid, done, fault_valid}, wb_data); end
        step();
    endtask
`else
    task automatic test_timeout();
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'hA000;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) step();
        n_cmp++; if ({mem_req, fault_valid, done} !== 3'b100) begin n_err++; $display("FAIL no-timeout wait: got %b want 100", {mem_req, fault_valid, done}); end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({wb_valid, done, fault_valid} !== 3'b110 || wb_data !== 32'h0BADF00D) begin n_err++; $display("FAIL no-timeout ack: got %b %h want 110 0badf00d", {wb_valid, done, fault_valid}, wb_data); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_in_bus();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
